// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard controller: register scoreboard, branch-wait/flush FSM,
// sticky error flags and stall/flush performance counters.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        de_valid,
    input  logic [4:0]  de_rs1,
    input  logic [4:0]  de_rs2,
    input  logic        de_rs1_used,
    input  logic        de_rs2_used,
    input  logic [4:0]  de_rd,
    input  logic        de_wr_reg,
    input  logic        de_is_branch,
    input  logic        agex_br_valid,
    input  logic        agex_br_taken,
    input  logic        wb_valid,
    input  logic        wb_wr_reg,
    input  logic [4:0]  wb_rd,
    output logic        stall_fe,
    output logic        stall_de,
    output logic        issue,
    output logic        bubble_agex,
    output logic        flush_de,
    output logic        err_underflow,
    output logic        err_spurious_br,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt [1:31];
    logic [1:0]  eff [0:31];
    logic [31:1] hit_vec, inc_vec, uf_vec;
    logic        data_hz, struct_hz;

    // A writeback against an empty counter has nothing to retire, so the
    // effective count saturates at zero instead of wrapping to 3.
    always_comb begin
        eff[0]  = '0;
        hit_vec = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            hit_vec[i] = wb_valid & wb_wr_reg & (wb_rd == 5'(i));
            eff[i]     = (hit_vec[i] && cnt[i] != 2'd0) ? cnt[i] - 2'd1 : cnt[i];
        end
    end

    always_comb begin
        data_hz = (de_rs1_used && de_rs1 != 5'd0 && eff[de_rs1] != 2'd0) ||
                  (de_rs2_used && de_rs2 != 5'd0 && eff[de_rs2] != 2'd0);
        struct_hz = de_wr_reg && de_rd != 5'd0 && eff[de_rd] == 2'd3;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        stall_de  = 1'b0;
        stall_fe  = 1'b0;
        flush_de  = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    issue    = de_valid & ~data_hz & ~struct_hz;
                    stall_de = de_valid & (data_hz | struct_hz);
                    if (issue && de_is_branch)
                        state_nxt = BR_WAIT;
                end
                BR_WAIT: begin
                    stall_de = de_valid;
                    if (agex_br_valid)
                        state_nxt = agex_br_taken ? FLUSH : RUN;
                end
                FLUSH: begin
                    flush_de  = 1'b1;
                    state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
            stall_fe = stall_de | flush_de;
        end
    end

    assign bubble_agex = ~issue;

    always_comb begin
        inc_vec = '0;
        uf_vec  = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            inc_vec[i] = issue & de_wr_reg & (de_rd == 5'(i));
            uf_vec[i]  = hit_vec[i] & ~inc_vec[i] & (cnt[i] == 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RUN;
            stall_cnt       <= '0;
            flush_cnt       <= '0;
            err_underflow   <= 1'b0;
            err_spurious_br <= 1'b0;
            for (int unsigned i = 1; i < 32; i++)
                cnt[i] <= '0;
        end else begin
            state <= state_nxt;
            for (int unsigned i = 1; i < 32; i++) begin
                if (inc_vec[i] && !hit_vec[i])
                    cnt[i] <= cnt[i] + 2'd1;
                else if (hit_vec[i] && !inc_vec[i] && cnt[i] != 2'd0)
                    cnt[i] <= cnt[i] - 2'd1;
            end
            if (|uf_vec)
                err_underflow <= 1'b1;
            if (agex_br_valid && state != BR_WAIT)
                err_spurious_br <= 1'b1;
            if (stall_de)
                stall_cnt <= stall_cnt + 32'd1;
            if (state_nxt == FLUSH && state != FLUSH)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a randomized
// run against a pending-write/branch-flag reference model.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        de_valid, de_rs1_used, de_rs2_used, de_wr_reg, de_is_branch;
    logic [4:0]  de_rs1, de_rs2, de_rd, wb_rd;
    logic        agex_br_valid, agex_br_taken, wb_valid, wb_wr_reg;
    logic        stall_fe, stall_de, issue, bubble_agex, flush_de;
    logic        err_underflow, err_spurious_br;
    logic [31:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: outstanding writes per register and branch status flags.
    int          pend [32];
    bit          m_br_wait, m_flush, m_uf, m_sp;
    int unsigned m_stall, m_flushes;
    bit          x_issue, x_stall_de, x_stall_fe, x_flush;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .de_rd(de_rd), .de_wr_reg(de_wr_reg), .de_is_branch(de_is_branch),
        .agex_br_valid(agex_br_valid), .agex_br_taken(agex_br_taken),
        .wb_valid(wb_valid), .wb_wr_reg(wb_wr_reg), .wb_rd(wb_rd),
        .stall_fe(stall_fe), .stall_de(stall_de), .issue(issue),
        .bubble_agex(bubble_agex), .flush_de(flush_de),
        .err_underflow(err_underflow), .err_spurious_br(err_spurious_br),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit wb_hits(int r);
        return wb_valid && wb_wr_reg && int'(wb_rd) == r && r != 0;
    endfunction

    function automatic int outstanding(int r);
        int e;
        if (r == 0) return 0;
        e = pend[r] - int'(wb_hits(r));
        return (e < 0) ? 0 : e;
    endfunction

    task automatic model_eval();
        bit raw, full;
        raw  = (de_rs1_used && outstanding(int'(de_rs1)) > 0) ||
               (de_rs2_used && outstanding(int'(de_rs2)) > 0);
        full = de_wr_reg && outstanding(int'(de_rd)) >= 3;
        if (reset) begin
            x_issue = 0; x_stall_de = 0; x_stall_fe = 0; x_flush = 0;
        end else begin
            x_flush    = m_flush;
            x_issue    = de_valid && !m_br_wait && !m_flush && !raw && !full;
            x_stall_de = de_valid && (m_br_wait || (!m_flush && (raw || full)));
            x_stall_fe = x_stall_de || m_flush;
        end
    endtask

    task automatic model_update();
        if (reset) begin
            foreach (pend[r]) pend[r] = 0;
            m_br_wait = 0; m_flush = 0; m_uf = 0; m_sp = 0;
            m_stall = 0; m_flushes = 0;
            return;
        end
        for (int r = 1; r < 32; r++) begin
            bit inc, hit;
            inc = x_issue && de_wr_reg && int'(de_rd) == r;
            hit = wb_hits(r);
            if (inc && !hit) pend[r]++;
            else if (hit && !inc) begin
                if (pend[r] == 0) m_uf = 1;
                else pend[r]--;
            end
        end
        if (agex_br_valid && !m_br_wait) m_sp = 1;
        if (x_stall_de) m_stall++;
        if (m_flush) m_flush = 0;
        else if (m_br_wait) begin
            if (agex_br_valid) begin
                m_br_wait = 0;
                if (agex_br_taken) begin
                    m_flush = 1;
                    m_flushes++;
                end
            end
        end else if (x_issue && de_is_branch) m_br_wait = 1;
    endtask

    task automatic tick();
        model_eval();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_rs1_used = 0;
        de_rs2_used = 0; de_rd = 0; de_wr_reg = 0; de_is_branch = 0;
        agex_br_valid = 0; agex_br_taken = 0; wb_valid = 0; wb_wr_reg = 0; wb_rd = 0;
    endtask

    task automatic set_de(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                          input logic u2, input logic [4:0] rd, input logic wr, input logic br);
        de_valid = 1; de_rs1 = r1; de_rs1_used = u1; de_rs2 = r2; de_rs2_used = u2;
        de_rd = rd; de_wr_reg = wr; de_is_branch = br;
    endtask

    task automatic set_wb(input logic [4:0] rd);
        wb_valid = 1; wb_wr_reg = 1; wb_rd = rd;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        set_de(5'd1, 1, 5'd2, 1, 5'd3, 1, 1);
        agex_br_valid = 1; agex_br_taken = 1; set_wb(5'd9);
        #1;
        n_cmp++;
        if ({stall_fe, stall_de, flush_de, issue, bubble_agex} !== 5'b00001) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 00001",
                     {stall_fe, stall_de, flush_de, issue, bubble_agex});
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if ({err_underflow, err_spurious_br, stall_cnt, flush_cnt} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset_state: uf=%b sp=%b stall=%0d flush=%0d want all 0",
                     err_underflow, err_spurious_br, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_raw_stall();
        set_de(5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
        #1;
        n_cmp++;
        if (issue !== 1'b1) begin n_bad++; $display("FAIL raw_producer_issue: got %b want 1", issue); end
        tick();
        set_de(5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({stall_de, issue} !== 2'b10) begin
                n_bad++;
                $display("FAIL raw_stall[%0d]: stall_de,issue got %b want 10", i, {stall_de, issue});
            end
            tick();
        end
        set_wb(5'd5);
        #1;
        n_cmp++;
        if ({stall_de, issue} !== 2'b01) begin
            n_bad++;
            $display("FAIL raw_release: stall_de,issue got %b want 01", {stall_de, issue});
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (stall_cnt !== 32'd3) begin n_bad++; $display("FAIL raw_stall_cnt: got %0d want 3", stall_cnt); end
    endtask

    task automatic test_branch_taken();
        do_reset();
        set_de(5'd0, 0, 5'd0, 0, 5'd0, 0, 1);
        #1;
        n_cmp++;
        if (issue !== 1'b1) begin n_bad++; $display("FAIL bt_branch_issue: got %b want 1", issue); end
        tick();
        set_de(5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
        #1;
        n_cmp++;
        if ({stall_fe, stall_de, issue} !== 3'b110) begin
            n_bad++;
            $display("FAIL bt_wait_stall: fe,de,issue got %b want 110", {stall_fe, stall_de, issue});
        end
        tick();
        agex_br_valid = 1; agex_br_taken = 1;
        #1;
        n_cmp++;
        if (stall_de !== 1'b1) begin n_bad++; $display("FAIL bt_resolve_stall: got %b want 1", stall_de); end
        tick();
        agex_br_valid = 0; agex_br_taken = 0;
        #1;
        n_cmp++;
        if ({flush_de, stall_fe, stall_de, issue} !== 4'b1100 || flush_cnt !== 32'd1) begin
            n_bad++;
            $display("FAIL bt_flush: flush,fe,de,issue got %b want 1100, flush_cnt got %0d want 1",
                     {flush_de, stall_fe, stall_de, issue}, flush_cnt);
        end
        tick();
        #1;
        n_cmp++;
        if ({flush_de, issue} !== 2'b01) begin
            n_bad++;
            $display("FAIL bt_resume: flush,issue got %b want 01", {flush_de, issue});
        end
        tick();
        idle();
    endtask

    task automatic test_branch_not_taken();
        do_reset();
        set_de(5'd0, 0, 5'd0, 0, 5'd0, 0, 1);
        tick();
        set_de(5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
        agex_br_valid = 1; agex_br_taken = 0;
        #1;
        n_cmp++;
        if (stall_de !== 1'b1) begin n_bad++; $display("FAIL bnt_wait_stall: got %b want 1", stall_de); end
        tick();
        agex_br_valid = 0;
        #1;
        n_cmp++;
        if ({flush_de, issue} !== 2'b01 || flush_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL bnt_resume: flush,issue got %b want 01, flush_cnt got %0d want 0",
                     {flush_de, issue}, flush_cnt);
        end
        tick();
        idle();
    endtask

    task automatic test_structural();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_de(5'd0, 0, 5'd0, 0, 5'd7, 1, 0);
            #1;
            n_cmp++;
            if (issue !== 1'b1) begin n_bad++; $display("FAIL st_fill[%0d]: issue got %b want 1", i, issue); end
            tick();
        end
        #1;
        n_cmp++;
        if ({stall_de, issue} !== 2'b10) begin
            n_bad++;
            $display("FAIL st_full: stall_de,issue got %b want 10", {stall_de, issue});
        end
        tick();
        set_wb(5'd7);
        #1;
        n_cmp++;
        if (issue !== 1'b1) begin n_bad++; $display("FAIL st_release: issue got %b want 1", issue); end
        tick();
        wb_valid = 0; wb_wr_reg = 0;
        #1;
        n_cmp++;
        if (stall_de !== 1'b1) begin n_bad++; $display("FAIL st_still_full: stall_de got %b want 1", stall_de); end
        tick();
        idle();
    endtask

    task automatic test_x0_and_errors();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_de(5'd0, 1, 5'd0, 1, 5'd0, 1, 0);
            #1;
            n_cmp++;
            if ({stall_de, issue} !== 2'b01) begin
                n_bad++;
                $display("FAIL x0_no_stall[%0d]: stall_de,issue got %b want 01", i, {stall_de, issue});
            end
            tick();
        end
        idle();
        set_wb(5'd5);
        tick();
        idle();
        n_cmp++;
        if (err_underflow !== 1'b1) begin n_bad++; $display("FAIL underflow_set: got %b want 1", err_underflow); end
        tick();
        n_cmp++;
        if (err_underflow !== 1'b1) begin n_bad++; $display("FAIL underflow_sticky: got %b want 1", err_underflow); end
        agex_br_valid = 1;
        tick();
        idle();
        n_cmp++;
        if (err_spurious_br !== 1'b1) begin n_bad++; $display("FAIL spurious_br: got %b want 1", err_spurious_br); end
    endtask

    task automatic test_reset_in_br_wait();
        do_reset();
        set_de(5'd0, 0, 5'd0, 0, 5'd3, 1, 0);
        tick();
        tick();
        set_de(5'd0, 0, 5'd0, 0, 5'd0, 0, 1);
        tick();
        idle();
        reset = 1;
        tick();
        reset = 0;
        set_de(5'd3, 1, 5'd3, 1, 5'd0, 0, 0);
        #1;
        n_cmp++;
        if ({stall_de, issue} !== 2'b01) begin
            n_bad++;
            $display("FAIL rst_brwait_issue: stall_de,issue got %b want 01", {stall_de, issue});
        end
        tick();
        idle();
        set_wb(5'd3);
        tick();
        idle();
        n_cmp++;
        if (err_underflow !== 1'b1) begin n_bad++; $display("FAIL rst_discard_uf: got %b want 1", err_underflow); end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset         = ($urandom_range(0, 99) == 0);
            de_valid      = ($urandom_range(0, 3) != 0);
            de_rs1        = 5'($urandom_range(0, 7));
            de_rs2        = 5'($urandom_range(0, 7));
            de_rs1_used   = 1'($urandom_range(0, 1));
            de_rs2_used   = 1'($urandom_range(0, 1));
            de_rd         = 5'($urandom_range(0, 7));
            de_wr_reg     = 1'($urandom_range(0, 1));
            de_is_branch  = ($urandom_range(0, 9) == 0);
            agex_br_valid = m_br_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            agex_br_taken = 1'($urandom_range(0, 1));
            r             = $urandom_range(0, 7);
            wb_rd         = 5'(r);
            wb_valid      = (pend[r] > 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 29) == 0);
            wb_wr_reg     = ($urandom_range(0, 9) != 0);
            #1;
            model_eval();
            n_cmp++;
            if ({stall_fe, stall_de, issue, bubble_agex, flush_de} !==
                {x_stall_fe, x_stall_de, x_issue, ~x_issue, x_flush}) begin
                n_bad++;
                $display("FAIL rand_ctrl[%0d]: fe,de,issue,bubble,flush got %b want %b", cyc,
                         {stall_fe, stall_de, issue, bubble_agex, flush_de},
                         {x_stall_fe, x_stall_de, x_issue, ~x_issue, x_flush});
            end
            n_cmp++;
            if ({err_underflow, err_spurious_br, stall_cnt, flush_cnt} !== {m_uf, m_sp, m_stall, m_flushes}) begin
                n_bad++;
                $display("FAIL rand_state[%0d]: uf=%b sp=%b stall=%0d flush=%0d want uf=%b sp=%b stall=%0d flush=%0d",
                         cyc, err_underflow, err_spurious_br, stall_cnt, flush_cnt,
                         m_uf, m_sp, m_stall, m_flushes);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        foreach (pend[r]) pend[r] = 0;
        m_br_wait = 0; m_flush = 0; m_uf = 0; m_sp = 0; m_stall = 0; m_flushes = 0;
        #1;
        test_reset();
        test_raw_stall();
        test_branch_taken();
        test_branch_not_taken();
        test_structural();
        test_x0_and_errors();
        test_reset_in_br_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001: clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: de_valid  input  1  DE latch holds a valid decoded instruction.
REQ-004: de_rs1, de_rs2  input  5 each  source register indices.
REQ-005: de_rs1_used, de_rs2_used  input  1 each  instruction reads that source.
REQ-006: de_rd  input  5  destination register index.
REQ-007: de_wr_reg  input  1  instruction writes de_rd.
REQ-008: de_is_branch  input  1  instruction is a conditional branch.
REQ-009: agex_br_valid  input  1  AGEX resolves a branch this cycle.
REQ-010: agex_br_taken  input  1  resolved branch is taken; qualified by agex_br_valid.
REQ-011: wb_valid, wb_wr_reg  input  1 each  WB retires an instruction that writes a register.
REQ-012: wb_rd  input  5  WB destination index.
REQ-013: stall_fe, stall_de  output  1 each  hold FE PC and DE latch.
REQ-014: issue  output  1  DE instruction accepted into AGEX this cycle.
REQ-015: bubble_agex  output  1  AGEX latch loads a NOP (equals ~issue).
REQ-016: flush_de  output  1  discard DE latch contents (wrong path).
REQ-017: err_underflow, err_spurious_br  output  1 each  sticky error flags.
REQ-018: stall_cnt, flush_cnt  output  32 each  performance counters.

Function
REQ-019: Scoreboard: one 2-bit pending-write counter per register x1..x31; x0 never tracked, always reads 0.
REQ-020: Define wb_hit(r) = wb_valid & wb_wr_reg & (wb_rd==r) & (r!=0); eff(r) = cnt[r] - wb_hit(r).
REQ-021: Data hazard = (de_rs1_used & de_rs1!=0 & eff(de_rs1)!=0) | (de_rs2_used & de_rs2!=0 & eff(de_rs2)!=0).
REQ-022: Structural hazard = de_wr_reg & de_rd!=0 & eff(de_rd)==3.
REQ-023: FSM states: RUN, BR_WAIT, FLUSH; reset state RUN.
REQ-024: stall_de = de_valid & (data hazard | structural hazard | state!=RUN); stall_fe = stall_de | (state==FLUSH); in FLUSH stall_de=0.
REQ-025: issue = de_valid & state==RUN & ~data hazard & ~structural hazard; combinational, same cycle.
REQ-026: On issue with de_wr_reg & de_rd!=0: cnt[de_rd] increments at next edge.
REQ-027: On wb_hit(r): cnt[r] decrements; simultaneous issue-increment and wb-decrement on same register yields net no change.
REQ-028: wb_hit on cnt[r]==0 (no simultaneous increment): cnt stays 0, err_underflow set.
REQ-029: RUN -> BR_WAIT when issue & de_is_branch.
REQ-030: BR_WAIT: agex_br_valid & agex_br_taken -> FLUSH; agex_br_valid & ~agex_br_taken -> RUN; else remain.
REQ-031: FLUSH lasts exactly one cycle: flush_de=1, issue=0, then RUN.
REQ-032: agex_br_valid while state==RUN or FLUSH: ignored, err_spurious_br set.
REQ-033: stall_cnt increments each cycle stall_de=1; flush_cnt increments on each entry to FLUSH; both wrap at 2^32.

Reset
REQ-034: reset clears all scoreboard counters, state=RUN, stall_cnt=flush_cnt=0, error flags=0.
REQ-035: During reset cycle, all inputs ignored; outputs stall_fe=stall_de=flush_de=issue=0, bubble_agex=1.
REQ-036: Reset mid-BR_WAIT or with pending writes discards them; later wb of discarded writes sets err_underflow.

Verification
REQ-037: Issue ADD rd=x5; next cycle DE reads rs1=x5 -> stall_de=1 until WB of x5 cycle, issue=1 that same WB cycle; stall_cnt equals stall cycles.
REQ-038: Issue BEQ; next cycle valid instruction in DE -> stall_de=1; agex_br_valid=1, taken=1 -> next cycle flush_de=1, stall_fe=1, flush_cnt=1; following cycle state RUN.
REQ-039: BEQ resolved not-taken -> no flush_de, issue resumes next cycle, flush_cnt=0.
REQ-040: Three back-to-back writes to x7 without WB -> fourth write to x7 stalls (cnt=3); one WB to x7 same cycle releases it, cnt stays 3.
REQ-041: Instruction reading/writing x0 with pending x0 issue -> never stalls; wb to x5 with cnt 0 -> err_underflow=1, remains 1.
REQ-042: reset asserted in BR_WAIT with cnt[x3]=2 -> next cycle state RUN, read of x3 issues without stall.
